// File: rtl/uart_fifo_transmitter_if.sv
// FIFO read-side handshake between the dual-clock FIFO and its UART transmit consumer.
// Master is the consumer (drives the pop strobe); slave is the FIFO read port.
interface uart_fifo_transmitter_if #(
  parameter int DATAWIDTH = 8
);
  logic                 fifoReadReq;
  logic                 fifoEmpty;
  logic [DATAWIDTH-1:0] fifoData;

  modport master (
    output fifoReadReq,
    input  fifoEmpty,
    input  fifoData
  );

  modport slave (
    input  fifoReadReq,
    output fifoEmpty,
    output fifoData
  );
endinterface

// File: rtl/uart_fifo_transmitter.sv
// UART transmit path: pops one word per frame from the dual-clock FIFO and serialises it
// as start bit, DATAWIDTH data bits LSB first, STOPBITS stop bits. All outputs are registered.
module uart_fifo_transmitter #(
  parameter int DATAWIDTH = 8,
  parameter int DIVWIDTH  = 16,
  parameter int STOPBITS  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DIVWIDTH-1:0]    baudDivisor,
  uart_fifo_transmitter_if.master fifo,
  output logic                   txd,
  output logic                   busy,
  output logic                   txDone
);

  localparam int BITW = $clog2(DATAWIDTH + 1);

  localparam logic [DIVWIDTH-1:0] CNT_ZERO  = {DIVWIDTH{1'b0}};
  localparam logic [DIVWIDTH-1:0] CNT_ONE   = {{(DIVWIDTH-1){1'b0}}, 1'b1};
  localparam logic [BITW-1:0]     BIT_ZERO  = {BITW{1'b0}};
  localparam logic [BITW-1:0]     BIT_ONE   = {{(BITW-1){1'b0}}, 1'b1};
  localparam logic [BITW-1:0]     LAST_DATA = BITW'(DATAWIDTH - 1);
  localparam logic [BITW-1:0]     LAST_STOP = BITW'(STOPBITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [DIVWIDTH-1:0]  cnt_q, cnt_d;
  logic [DIVWIDTH-1:0]  div_q, div_d;
  logic [BITW-1:0]      bit_q, bit_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rdreq_q, rdreq_d;

  // Next-state, bit timing and shift logic; outputs are decoded from the next state so
  // that their registers line up cycle-for-cycle with state_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        if (enable && !fifo.fifoEmpty) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // FIFO data is valid now, one cycle after the pop strobe.
        shift_d = fifo.fifoData;
        div_d   = baudDivisor;
        cnt_d   = baudDivisor;
        bit_d   = BIT_ZERO;
        state_d = START;
      end
      START: begin
        if (cnt_q == CNT_ZERO) begin
          cnt_d   = div_q;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == CNT_ZERO) begin
          cnt_d   = div_q;
          shift_d = {1'b0, shift_q[DATAWIDTH-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = BIT_ZERO;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == CNT_ZERO) begin
          cnt_d = div_q;
          if (bit_q == LAST_STOP) begin
            bit_d   = BIT_ZERO;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rdreq_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP) && (cnt_d == CNT_ZERO) && (bit_d == LAST_STOP);

    if (state_d == START) begin
      txd_d = 1'b0;
    end else if (state_d == DATA) begin
      txd_d = shift_d[0];
    end else begin
      txd_d = 1'b1;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      div_q   <= CNT_ZERO;
      bit_q   <= BIT_ZERO;
      shift_q <= {DATAWIDTH{1'b0}};
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdreq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdreq_q <= rdreq_d;
    end
  end

  assign fifo.fifoReadReq = rdreq_q;
  assign txd              = txd_q;
  assign busy             = busy_q;
  assign txDone           = done_q;

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// Directed bench for uart_fifo_transmitter (DATAWIDTH=8, STOPBITS=1) with a small
// behavioural read-side FIFO model and hand-derived frame waveforms.
module tb_uart_fifo_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] baudDivisor;
  logic        txd;
  logic        busy;
  logic        txDone;

  int total = 0;
  int bad   = 0;

  uart_fifo_transmitter_if #(.DATAWIDTH(8)) fifo_if ();

  uart_fifo_transmitter #(
    .DATAWIDTH(8),
    .DIVWIDTH (16),
    .STOPBITS (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .baudDivisor(baudDivisor),
    .fifo       (fifo_if),
    .txd        (txd),
    .busy       (busy),
    .txDone     (txDone)
  );

  always #5 clk = ~clk;

  // FIFO model: dataOut becomes valid the cycle after readReq is sampled high.
  logic [7:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always @(posedge clk) begin
    if (fifo_if.fifoReadReq && (rd_ptr != wr_ptr)) begin
      fifo_if.fifoData <= mem[rd_ptr % 32];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always_comb fifo_if.fifoEmpty = (rd_ptr == wr_ptr);

  int pop_cnt  = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (fifo_if.fifoReadReq === 1'b1) pop_cnt++;
    if (txDone === 1'b1) done_cnt++;
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 32] = d;
    wr_ptr++;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
    else return 1'b1;
  endfunction

  logic txd_log  [0:127];
  logic done_log [0:127];
  logic busy_log [0:127];

  // Waits (bounded) for a start bit, then records len cycles starting with it.
  task automatic watch_frame(input int len, input int chg_at, input logic [15:0] new_div,
                             output bit found);
    found = 1'b0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    if (found) begin
      for (int i = 0; i < len; i++) begin
        if (i > 0) @(negedge clk);
        if (i == chg_at) baudDivisor = new_div;
        txd_log[i]  = txd;
        done_log[i] = txDone;
        busy_log[i] = busy;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    baudDivisor = 16'd3;
    push(8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({txd, fifo_if.fifoReadReq, busy, txDone} !== 4'b1000) begin
        bad++;
        $display("FAIL reset_outputs: txd/req/busy/done got %b%b%b%b want 1000",
                 txd, fifo_if.fifoReadReq, busy, txDone);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit found;
    int p0;
    p0 = pop_cnt;
    watch_frame(44, -1, 16'd0, found);
    total++;
    if (!found) begin
      bad++;
      $display("FAIL single_start: got no start bit want start bit");
    end else begin
      for (int i = 0; i < 40; i++) begin
        total++;
        if (txd_log[i] !== exp_bit(8'hA5, i / 4)) begin
          bad++;
          $display("FAIL single_txd[%0d]: got %b want %b", i, txd_log[i], exp_bit(8'hA5, i / 4));
        end
        total++;
        if (done_log[i] !== (i == 39)) begin
          bad++;
          $display("FAIL single_done[%0d]: got %b want %b", i, done_log[i], (i == 39));
        end
      end
      total++;
      if (busy_log[39] !== 1'b1 || busy_log[40] !== 1'b0 || txd_log[40] !== 1'b1) begin
        bad++;
        $display("FAIL single_end: busy39=%b busy40=%b txd40=%b want 1 0 1",
                 busy_log[39], busy_log[40], txd_log[40]);
      end
    end
    total++;
    if (pop_cnt - p0 !== 1) begin
      bad++;
      $display("FAIL single_pops: got %0d want 1", pop_cnt - p0);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    int p0;
    logic [7:0] w [3];
    w[0] = 8'h00;
    w[1] = 8'hFF;
    w[2] = 8'h55;
    baudDivisor = 16'd0;
    p0 = pop_cnt;
    push(w[0]);
    push(w[1]);
    push(w[2]);
    watch_frame(37, -1, 16'd0, found);
    total++;
    if (!found) begin
      bad++;
      $display("FAIL b2b_start: got no start bit want start bit");
    end else begin
      for (int f = 0; f < 3; f++) begin
        for (int k = 0; k < 10; k++) begin
          total++;
          if (txd_log[f*13+k] !== exp_bit(w[f], k) || done_log[f*13+k] !== (k == 9)) begin
            bad++;
            $display("FAIL b2b_frame%0d_bit%0d: txd=%b done=%b want txd=%b done=%b",
                     f, k, txd_log[f*13+k], done_log[f*13+k], exp_bit(w[f], k), (k == 9));
          end
        end
        if (f < 2) begin
          for (int g = 10; g < 13; g++) begin
            total++;
            if (txd_log[f*13+g] !== 1'b1) begin
              bad++;
              $display("FAIL b2b_gap%0d_%0d: got txd=%b want 1", f, g, txd_log[f*13+g]);
            end
          end
        end
      end
      total++;
      if (busy_log[36] !== 1'b0) begin
        bad++;
        $display("FAIL b2b_idle_busy: got %b want 0", busy_log[36]);
      end
    end
    total++;
    if (pop_cnt - p0 !== 3) begin
      bad++;
      $display("FAIL b2b_pops: got %0d want 3", pop_cnt - p0);
    end
  endtask

  task automatic test_empty_enable();
    int badcyc;
    int p0;
    int d0;
    bit found;
    baudDivisor = 16'd1;
    enable = 1'b1;
    badcyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_if.fifoReadReq !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) badcyc++;
    end
    total++;
    if (badcyc !== 0) begin
      bad++;
      $display("FAIL empty_quiet: got %0d active cycles want 0", badcyc);
    end
    enable = 1'b0;
    push(8'h11);
    badcyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_if.fifoReadReq !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) badcyc++;
    end
    total++;
    if (badcyc !== 0) begin
      bad++;
      $display("FAIL disabled_quiet: got %0d active cycles want 0", badcyc);
    end
    push(8'h22);
    p0 = pop_cnt;
    d0 = done_cnt;
    enable = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL enable_start: got no start bit want start bit");
    end
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1 || pop_cnt - p0 !== 1) begin
      bad++;
      $display("FAIL enable_drop: done=%0d pops=%0d want 1 1", done_cnt - d0, pop_cnt - p0);
    end
    total++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL enable_drop_idle: txd=%b busy=%b want 1 0", txd, busy);
    end
    enable = 1'b1;
    watch_frame(21, -1, 16'd0, found);
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reenable_start: got no start bit want start bit");
    end else begin
      for (int i = 0; i < 20; i++) begin
        total++;
        if (txd_log[i] !== exp_bit(8'h22, i / 2) || done_log[i] !== (i == 19)) begin
          bad++;
          $display("FAIL reenable_bit[%0d]: txd=%b done=%b want txd=%b done=%b",
                   i, txd_log[i], done_log[i], exp_bit(8'h22, i / 2), (i == 19));
        end
      end
      total++;
      if (busy_log[20] !== 1'b0) begin
        bad++;
        $display("FAIL reenable_end_busy: got %b want 0", busy_log[20]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    baudDivisor = 16'd3;
    push(8'hC3);
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rstmid_start: got no start bit want start bit");
    end
    repeat (21) @(negedge clk);
    total++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_bit4: txd=%b busy=%b want 0 1", txd, busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({txd, fifo_if.fifoReadReq, busy, txDone} !== 4'b1000) begin
      bad++;
      $display("FAIL rstmid_async: txd/req/busy/done got %b%b%b%b want 1000",
               txd, fifo_if.fifoReadReq, busy, txDone);
    end
    push(8'h5A);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    watch_frame(41, -1, 16'd0, found);
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rstmid_restart: got no start bit want start bit");
    end else begin
      for (int i = 0; i < 40; i++) begin
        total++;
        if (txd_log[i] !== exp_bit(8'h5A, i / 4) || done_log[i] !== (i == 39)) begin
          bad++;
          $display("FAIL rstmid_frame[%0d]: txd=%b done=%b want txd=%b done=%b",
                   i, txd_log[i], done_log[i], exp_bit(8'h5A, i / 4), (i == 39));
        end
      end
      total++;
      if (busy_log[40] !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_end_busy: got %b want 0", busy_log[40]);
      end
    end
  endtask

  task automatic test_divisor();
    bit found;
    baudDivisor = 16'd3;
    push(8'h81);
    push(8'h7E);
    watch_frame(124, 10, 16'd7, found);
    total++;
    if (!found) begin
      bad++;
      $display("FAIL div_start: got no start bit want start bit");
    end else begin
      for (int i = 0; i < 40; i++) begin
        total++;
        if (txd_log[i] !== exp_bit(8'h81, i / 4) || done_log[i] !== (i == 39)) begin
          bad++;
          $display("FAIL div_frame1[%0d]: txd=%b done=%b want txd=%b done=%b",
                   i, txd_log[i], done_log[i], exp_bit(8'h81, i / 4), (i == 39));
        end
      end
      for (int i = 40; i < 43; i++) begin
        total++;
        if (txd_log[i] !== 1'b1) begin
          bad++;
          $display("FAIL div_gap[%0d]: got %b want 1", i, txd_log[i]);
        end
      end
      for (int i = 43; i < 123; i++) begin
        total++;
        if (txd_log[i] !== exp_bit(8'h7E, (i - 43) / 8) || done_log[i] !== (i == 122)) begin
          bad++;
          $display("FAIL div_frame2[%0d]: txd=%b done=%b want txd=%b done=%b",
                   i, txd_log[i], done_log[i], exp_bit(8'h7E, (i - 43) / 8), (i == 122));
        end
      end
      total++;
      if (busy_log[123] !== 1'b0) begin
        bad++;
        $display("FAIL div_end_busy: got %b want 0", busy_log[123]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty_enable();
    test_reset_mid();
    test_divisor();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
